// File: rtl/qft_mem_pkg.sv
// Shared types and default geometry for the banked amplitude memory.
// Used by the write sequencer and the matching read sequencer.
package qft_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    LOAD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int QM_N       = 1;
  localparam int QM_DEPTH_W = 4;
  localparam int QM_DATA_W  = 16;
  localparam int NUM_BANKS  = 2**QM_N;
  localparam int WORDS      = 2**QM_DEPTH_W;
  localparam int TOTAL      = 2**(QM_N + QM_DEPTH_W);

  // Amplitude word packs as {re, im}, re in the upper half.
  typedef struct packed {
    logic signed [QM_DATA_W-1:0] re;
    logic signed [QM_DATA_W-1:0] im;
  } amp_t;

endpackage

// File: rtl/amp_index_split.sv
// Splits a flat amplitude index into {word address, bank select}.
// The low bits pick the bank, so consecutive indices land in different banks.
module amp_index_split #(
  parameter int N       = 1,
  parameter int DEPTH_W = 4
) (
  input  logic [N+DEPTH_W-1:0] i_k,
  output logic [N-1:0]         o_sel,
  output logic [DEPTH_W-1:0]   o_addr
);

  assign o_sel  = i_k[N-1:0];
  assign o_addr = i_k[N+DEPTH_W-1:N];

endmodule

// File: rtl/amp_write_seq.sv
// Write sequencer for the banked amplitude memory: broadcast init of all banks,
// or a valid/ready stream load interleaved across banks. All outputs registered except s_ready.
module amp_write_seq
  import qft_mem_pkg::*;
#(
  parameter int N       = 1,
  parameter int DEPTH_W = 4,
  parameter int DATA_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_init,
  input  logic [2*DATA_W-1:0]   init_data,
  input  logic                  load_start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [2*DATA_W-1:0]   s_data,
  output logic [N-1:0]          sel,
  output logic                  all,
  output logic                  w_en,
  output logic [DEPTH_W-1:0]    addr,
  output logic [2*DATA_W-1:0]   wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  localparam int CW = N + DEPTH_W;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [2*DATA_W-1:0] r_init, w_init_nxt;
  logic [N-1:0]        r_sel, w_sel_nxt;
  logic                r_all, w_all_nxt;
  logic                r_w_en, w_w_en_nxt;
  logic [DEPTH_W-1:0]  r_addr, w_addr_nxt;
  logic [2*DATA_W-1:0] r_wr_data, w_wr_data_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic [N-1:0]        w_k_sel;
  logic [DEPTH_W-1:0]  w_k_addr;
  logic                w_hs;

  amp_index_split #(.N(N), .DEPTH_W(DEPTH_W)) u_split (
    .i_k    (r_cnt),
    .o_sel  (w_k_sel),
    .o_addr (w_k_addr)
  );

  // Stream handshake: a beat transfers on a rising edge where s_valid && s_ready;
  // s_ready depends only on state, never on s_valid. Unaccepted data stays with the source.
  assign s_ready   = (r_state == LOAD);
  assign w_hs      = s_valid & s_ready;
  assign dbg_state = r_state;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_init_nxt    = r_init;
    w_sel_nxt     = '0;
    w_all_nxt     = 1'b0;
    w_w_en_nxt    = 1'b0;
    w_addr_nxt    = '0;
    w_wr_data_nxt = '0;
    case (r_state)
      IDLE: begin
        // The first init write is issued on the same edge that accepts start_init.
        if (start_init) begin
          w_state_nxt   = INIT;
          w_init_nxt    = init_data;
          w_w_en_nxt    = 1'b1;
          w_all_nxt     = 1'b1;
          w_wr_data_nxt = init_data;
          w_cnt_nxt     = CW'(1);
        end else if (load_start) begin
          w_state_nxt = LOAD;
          w_cnt_nxt   = '0;
        end
      end
      INIT: begin
        w_w_en_nxt    = 1'b1;
        w_all_nxt     = 1'b1;
        w_addr_nxt    = r_cnt[DEPTH_W-1:0];
        w_wr_data_nxt = r_init;
        w_cnt_nxt     = r_cnt + 1'b1;
        if (r_cnt[DEPTH_W-1:0] == '1) w_state_nxt = DONE;
      end
      LOAD: begin
        if (w_hs) begin
          w_w_en_nxt    = 1'b1;
          w_sel_nxt     = w_k_sel;
          w_addr_nxt    = w_k_addr;
          w_wr_data_nxt = s_data;
          w_cnt_nxt     = r_cnt + 1'b1;
          if (r_cnt == '1) w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // Registered flags lag state by one cycle, so busy covers the final write.
    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_init    <= '0;
      r_sel     <= '0;
      r_all     <= 1'b0;
      r_w_en    <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_init    <= w_init_nxt;
      r_sel     <= w_sel_nxt;
      r_all     <= w_all_nxt;
      r_w_en    <= w_w_en_nxt;
      r_addr    <= w_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign sel     = r_sel;
  assign all     = r_all;
  assign w_en    = r_w_en;
  assign addr    = r_addr;
  assign wr_data = r_wr_data;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_amp_write_seq.sv
// Directed bench for amp_write_seq with N=1, DEPTH_W=2, DATA_W=16.
module tb_amp_write_seq;
  import qft_mem_pkg::*;

  localparam int N       = 1;
  localparam int DEPTH_W = 2;
  localparam int DATA_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_init = 1'b0;
  logic [31:0]       init_data = '0;
  logic              load_start = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [31:0]       s_data = '0;
  logic [N-1:0]      sel;
  logic              all;
  logic              w_en;
  logic [DEPTH_W-1:0] addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  amp_t amp;

  amp_write_seq #(.N(N), .DEPTH_W(DEPTH_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_init (start_init),
    .init_data  (init_data),
    .load_start (load_start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .sel        (sel),
    .all        (all),
    .w_en       (w_en),
    .addr       (addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_w_en"},    64'(w_en),    64'd0);
    chk({tag, "_all"},     64'(all),     64'd0);
    chk({tag, "_sel"},     64'(sel),     64'd0);
    chk({tag, "_addr"},    64'(addr),    64'd0);
    chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_busy"},    64'(busy),    64'd0);
    chk({tag, "_done"},    64'(done),    64'd0);
  endtask

  initial begin
    // Reset state
    step(); step();
    chk_idle_outputs("reset");
    chk("reset_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;
    step();
    chk_idle_outputs("post_reset");

    // Broadcast init: 4 writes, then done
    init_data  = 32'h4000_0000;
    start_init = 1'b1;
    step();
    start_init = 1'b0;
    init_data  = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      chk("init_w_en", 64'(w_en), 64'd1);
      chk("init_all",  64'(all),  64'd1);
      chk("init_sel",  64'(sel),  64'd0);
      chk("init_addr", 64'(addr), 64'(i));
      chk("init_data", 64'(wr_data), 64'h4000_0000);
      chk("init_busy", 64'(busy), 64'd1);
      chk("init_done", 64'(done), 64'd0);
      step();
    end
    chk("init_done_pulse", 64'(done), 64'd1);
    chk("init_done_w_en",  64'(w_en), 64'd0);
    chk("init_done_busy",  64'(busy), 64'd0);
    step();
    chk("init_done_once",  64'(done), 64'd0);
    chk("init_back_idle",  64'(dbg_state), 64'(IDLE));

    // Back-to-back load with boundary beat
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("load_s_ready", 64'(s_ready), 64'd1);
    chk("load_no_write", 64'(w_en), 64'd0);
    chk("load_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 8; k++) begin
      s_valid = 1'b1;
      s_data  = 32'(k);
      step();
      chk("load_w_en",  64'(w_en),    64'd1);
      chk("load_all",   64'(all),     64'd0);
      chk("load_sel",   64'(sel),     64'(k % 2));
      chk("load_addr",  64'(addr),    64'(k / 2));
      chk("load_data",  64'(wr_data), 64'(k));
      chk("load_ready", 64'(s_ready), (k == 7) ? 64'd0 : 64'd1);
    end
    s_data = 32'hDEAD_BEEF;
    step();
    chk("bound_ready", 64'(s_ready), 64'd0);
    chk("bound_w_en",  64'(w_en),    64'd0);
    chk("bound_done",  64'(done),    64'd1);
    step();
    chk("bound_ready2", 64'(s_ready), 64'd0);
    chk("bound_w_en2",  64'(w_en),    64'd0);
    chk("bound_done2",  64'(done),    64'd0);
    s_valid = 1'b0;

    // Stalled load: valid every other cycle
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      s_valid = 1'b0;
      step();
      chk("stall_gap_w_en", 64'(w_en), 64'd0);
      amp.re  = 16'(k + 16'h0100);
      amp.im  = 16'(k | 16'h8000);
      s_valid = 1'b1;
      s_data  = amp;
      step();
      chk("stall_w_en", 64'(w_en),    64'd1);
      chk("stall_sel",  64'(sel),     64'(k % 2));
      chk("stall_addr", 64'(addr),    64'(k / 2));
      chk("stall_data", 64'(wr_data), {32'd0, 16'(16'h0100 + k), 16'(16'h8000 + k)});
    end
    s_valid = 1'b0;
    step();
    chk("stall_done", 64'(done), 64'd1);
    chk("stall_w_en_end", 64'(w_en), 64'd0);
    step();

    // Collision: init wins; load_start during INIT ignored
    init_data  = 32'h0000_7FFF;
    start_init = 1'b1;
    load_start = 1'b1;
    step();
    start_init = 1'b0;
    chk("coll_state", 64'(dbg_state), 64'(INIT));
    chk("coll_ready", 64'(s_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("coll_w_en", 64'(w_en), 64'd1);
      chk("coll_all",  64'(all),  64'd1);
      chk("coll_addr", 64'(addr), 64'(i));
      chk("coll_data", 64'(wr_data), 64'h0000_7FFF);
      step();
      load_start = 1'b0;
    end
    chk("coll_done", 64'(done), 64'd1);
    chk("coll_w_en_end", 64'(w_en), 64'd0);
    step();
    chk("coll_idle", 64'(dbg_state), 64'(IDLE));
    chk("coll_no_load", 64'(s_ready), 64'd0);
    chk("coll_no_write", 64'(w_en), 64'd0);

    // Reset mid-load after the 3rd handshake
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_data  = 32'hA000 + 32'(k);
      step();
      chk("rst_pre_addr", 64'(addr), 64'(k / 2));
    end
    s_data = 32'hA003;
    rst = 1'b1;
    step();
    chk_idle_outputs("rst_mid");
    rst     = 1'b0;
    s_valid = 1'b0;
    step();
    chk("rst_no_done", 64'(done), 64'd0);
    chk("rst_no_w_en", 64'(w_en), 64'd0);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'h0000_0055;
    step();
    s_valid = 1'b0;
    chk("restart_w_en", 64'(w_en),    64'd1);
    chk("restart_sel",  64'(sel),     64'd0);
    chk("restart_addr", 64'(addr),    64'd0);
    chk("restart_data", 64'(wr_data), 64'h55);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/amp_write_seq.md
Name: amp_write_seq

Overview:
- Write sequencer that drives the banked amplitude-memory write-enable decoder: produces its bank select, broadcast-all flag and write strobe, plus word address and write data.
- Two jobs:
  - Broadcast-initialise every word of all 2^N banks to one value, for state-vector reset.
  - Stream-load 2^(N+DEPTH_W) signed complex amplitudes, interleaved across banks.
- Sits between the host/loader stream and the banked state-vector RAMs.

Parameters:
- N, 1, bank-select width; number of banks = 2^N.
- DEPTH_W, 4, word-address width per bank; words per bank = 2^DEPTH_W.
- DATA_W, 16, width of each signed component; amplitude word = {re, im} = 2*DATA_W bits.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_init  in  1  pulse; request a broadcast initialise.
- init_data  in  2*DATA_W  value written to every word during init; sampled on accepted start_init.
- load_start  in  1  pulse; request a stream load.
- s_valid  in  1  stream amplitude valid.
- s_ready  out  1  stream ready.
- s_data  in  2*DATA_W  stream amplitude {re, im}.
- sel  out  N  bank select to the decoder.
- all  out  1  broadcast flag to the decoder.
- w_en  out  1  write strobe to the decoder.
- addr  out  DEPTH_W  word address, common to all banks.
- wr_data  out  2*DATA_W  write data, common to all banks.
- busy  out  1  high while in INIT or LOAD.
- done  out  1  one-cycle pulse when init or load completes.

Behaviour:
- Clock and reset:
  - Single clock domain clk.
  - rst is synchronous and active-high.
  - While rst is high, all outputs are 0 (sel, all, w_en, addr, wr_data, s_ready, busy, done) and the FSM is in IDLE.
- Outputs: all outputs are registered except s_ready, which is a decode of state (high in LOAD only).
- FSM states and transitions:
  - IDLE:
    - start_init → INIT: latch init_data; counter ← 0.
    - else load_start → LOAD: counter ← 0.
    - start_init and load_start in the same cycle: init wins, load_start is dropped.
  - INIT:
    - Each cycle: w_en=1, all=1, sel=0, addr=counter, wr_data=latched init value.
    - Counter increments each cycle.
    - After addr = 2^DEPTH_W-1 is issued, go to DONE.
    - Exactly 2^DEPTH_W write cycles.
  - LOAD:
    - s_ready=1.
    - On handshake (s_valid & s_ready) with element index k, the next cycle presents: w_en=1, all=0, sel=k[N-1:0], addr=k[N+DEPTH_W-1:N], wr_data=s_data. Consecutive elements therefore go to different banks.
    - Cycles with no handshake give w_en=0 in the following cycle.
    - After the handshake of k = 2^(N+DEPTH_W)-1, go to DONE; s_ready drops in that same following cycle.
  - DONE: done=1 for exactly one cycle, w_en=0, busy=0; go to IDLE.
- Latency: 1 cycle from handshake to w_en; 1 cycle from IDLE start pulse to first init write.
- Counter:
  - Width N+DEPTH_W; no wrap-around ever reaches the memory.
  - Termination is detected on the last index, not on overflow.
- Ignored requests: start_init and load_start while busy or in DONE are ignored, not queued.
- s_data when s_ready=0: not consumed.
- Reset mid-operation: the write in flight is cancelled on the cycle rst is sampled. No further w_en, no done pulse, return to IDLE. A partially loaded memory is the controller's responsibility.
- N=0 is not supported; N ≥ 1 and DEPTH_W ≥ 1.

Decomposition:
- Shared package qft_mem_pkg:
  - state enum {IDLE, INIT, LOAD, DONE}.
  - localparams NUM_BANKS = 2**N, WORDS = 2**DEPTH_W, TOTAL = 2**(N+DEPTH_W).
  - typedef for the signed complex amplitude struct {re, im}.
- Sub-module: amp_index_split, a combinational split of index k into {addr, sel}; reusable by the matching read sequencer.
- Integration: the write-enable decoder is instantiated by the parent, not inside this block.

Test Plan (N=1, DEPTH_W=2, DATA_W=16):
- Init: start_init with init_data=32'h4000_0000 → the next 4 cycles have w_en=1, all=1, addr 0,1,2,3, wr_data=32'h4000_0000; done pulses in the 5th cycle; busy is high for cycles 1–4.
- Load: load_start, then 8 back-to-back beats with s_data=k → writes (sel,addr) = (0,0),(1,0),(0,1),(1,1),(0,2),(1,2),(0,3),(1,3) with wr_data=k; done one cycle after the last write; s_ready=0 afterwards.
- Stalls: load with s_valid deasserted every other cycle → w_en only follows handshake cycles; same 8 writes in order; no duplicates.
- Collisions:
  - start_init and load_start in the same cycle → INIT runs, no LOAD.
  - load_start during INIT → ignored; only 4 writes, then IDLE.
- Reset mid-load: rst high after the 3rd handshake → w_en=0 from that cycle on, outputs all 0, no done pulse; a following load_start restarts from (sel=0, addr=0).
- Boundary: after the 8th handshake, a 9th s_valid beat is not accepted (s_ready=0); data is unchanged and stays pending.
